// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared types and constants for the multi-port byte-enable
//            register-file memory.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  // Bits per byte lane
  localparam int BYTE_W = 8;

  // Array lifecycle: initialising after reset / on request, or usable
  typedef enum logic [0:0] {
    MEM_CLEAR = 1'b0,
    MEM_READY = 1'b1
  } mem_state_e;

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_mp_be_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_mp_be_if
// Purpose  : Bus bundle for mem_mp_be: clear/ready control, read ports,
//            write ports with byte enables and the collision flag.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_mp_be_if #(
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int AW          = 5,
  parameter int WIDTH       = 32
);
  import mem_pkg::*;

  localparam int BE = WIDTH / BYTE_W;

  logic                                  clear_req;
  logic                                  ready;
  logic [READ_PORTS-1:0]                 re;
  logic [READ_PORTS-1:0][AW-1:0]         raddr;
  logic [READ_PORTS-1:0][WIDTH-1:0]      rdata;
  logic [READ_PORTS-1:0]                 rvalid;
  logic [WRITE_PORTS-1:0]                we;
  logic [WRITE_PORTS-1:0][AW-1:0]        waddr;
  logic [WRITE_PORTS-1:0][BE-1:0]        wbe;
  logic [WRITE_PORTS-1:0][WIDTH-1:0]     wdata;
  logic                                  wr_collision;

  // Requester side
  modport master (
    output clear_req, re, raddr, we, waddr, wbe, wdata,
    input  ready, rdata, rvalid, wr_collision
  );

  // Memory side
  modport slave (
    input  clear_req, re, raddr, we, waddr, wbe, wdata,
    output ready, rdata, rvalid, wr_collision
  );

endinterface : mem_mp_be_if
`default_nettype wire

// File: rtl/mem_wr_merge.sv
`default_nettype none
// ============================================================================
// Module   : mem_wr_merge
// Purpose  : Combines all write-port requests aimed at one address into a
//            per-lane enable and merged data word. The highest-indexed port
//            wins each lane; a lane claimed by two ports flags a collision.
// Revision : 1.0 - initial release
// ============================================================================
module mem_wr_merge
  import mem_pkg::*;
#(
  parameter int WRITE_PORTS = 2,
  parameter int AW          = 5,
  parameter int WIDTH       = 32
) (
  input  logic [WRITE_PORTS-1:0]                     act,
  input  logic [WRITE_PORTS-1:0][AW-1:0]             waddr,
  input  logic [WRITE_PORTS-1:0][WIDTH/BYTE_W-1:0]   wbe,
  input  logic [WRITE_PORTS-1:0][WIDTH-1:0]          wdata,
  input  logic [AW-1:0]                              addr,
  output logic [WIDTH/BYTE_W-1:0]                    lane_we,
  output logic [WIDTH-1:0]                           lane_data,
  output logic                                       collision
);

  localparam int BE = WIDTH / BYTE_W;

  // Ascending port scan so later (higher) ports overwrite earlier lane claims
  always_comb begin
    lane_we   = '0;
    lane_data = '0;
    collision = 1'b0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      if (act[p] && (waddr[p] == addr)) begin
        for (int b = 0; b < BE; b++) begin
          if (wbe[p][b]) begin
            if (lane_we[b]) collision = 1'b1;
            lane_we[b] = 1'b1;
            lane_data[b*BYTE_W +: BYTE_W] = wdata[p][b*BYTE_W +: BYTE_W];
          end
        end
      end
    end
  end

endmodule : mem_wr_merge
`default_nettype wire

// File: rtl/mem_mp_be.sv
`default_nettype none
// ============================================================================
// Module   : mem_mp_be
// Purpose  : Multi-write / multi-read register-file memory with per-port
//            byte enables, highest-port-wins write merging, optional
//            read-during-write bypass, 0/1-cycle read latency and a hardware
//            clear sequencer so the storage array needs no reset.
// Revision : 1.0 - initial release
// ============================================================================
module mem_mp_be
  import mem_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               DEPTH        = 32,
  parameter int               READ_PORTS   = 2,
  parameter int               WRITE_PORTS  = 2,
  parameter int               BYPASS_EN    = 0,
  parameter int               READ_LATENCY = 0,
  parameter logic [WIDTH-1:0] INIT_VAL     = '0
) (
  input  logic        clock,
  input  logic        reset_n,
  mem_mp_be_if.slave  bus
);

  localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int            BE        = WIDTH / BYTE_W;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  mem_state_e                        r_state, w_state_nxt;
  logic [AW-1:0]                     r_clr_ptr, w_clr_ptr_nxt;
  logic                              w_ready;
  logic [WIDTH-1:0]                  r_mem [DEPTH];
  logic [WRITE_PORTS-1:0]            w_wact;
  logic [WRITE_PORTS-1:0][BE-1:0]    w_wlane_we;
  logic [WRITE_PORTS-1:0][WIDTH-1:0] w_wlane_data;
  logic [WRITE_PORTS-1:0]            w_wcoll;
  logic                              r_wr_collision;
  logic [READ_PORTS-1:0][WIDTH-1:0]  w_rdata_nxt;
  logic [READ_PORTS-1:0]             w_rvalid_nxt;

  assign w_ready = (r_state == MEM_READY);

  // State register and clear pointer; reset forces a fresh clear from entry 0
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= MEM_CLEAR;
      r_clr_ptr <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_ptr <= w_clr_ptr_nxt;
    end
  end

  // Next state: sweep every entry once, then serve until a clear is requested
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_ptr_nxt = r_clr_ptr;
    case (r_state)
      MEM_CLEAR: begin
        if (r_clr_ptr == LAST_ADDR) begin
          w_state_nxt   = MEM_READY;
          w_clr_ptr_nxt = '0;
        end else begin
          w_clr_ptr_nxt = r_clr_ptr + AW'(1);
        end
      end
      MEM_READY: begin
        if (bus.clear_req) begin
          w_state_nxt   = MEM_CLEAR;
          w_clr_ptr_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = MEM_CLEAR;
        w_clr_ptr_nxt = '0;
      end
    endcase
  end

  // A write port participates only when ready, enabled and in range
  always_comb begin
    w_wact = '0;
    for (int p = 0; p < WRITE_PORTS; p++) begin
      w_wact[p] = w_ready && bus.we[p] && (int'(bus.waddr[p]) < DEPTH);
    end
  end

  // One merge per write port, targeted at that port's own address
  for (genvar p = 0; p < WRITE_PORTS; p++) begin : g_wr_merge
    mem_wr_merge #(
      .WRITE_PORTS (WRITE_PORTS),
      .AW          (AW),
      .WIDTH       (WIDTH)
    ) u_merge (
      .act       (w_wact),
      .waddr     (bus.waddr),
      .wbe       (bus.wbe),
      .wdata     (bus.wdata),
      .addr      (bus.waddr[p]),
      .lane_we   (w_wlane_we[p]),
      .lane_data (w_wlane_data[p]),
      .collision (w_wcoll[p])
    );
  end

  // Storage update: clear sweep, or merged lanes (ports sharing an address
  // all carry the same merged word, so duplicate updates agree)
  always_ff @(posedge clock) begin
    if (r_state == MEM_CLEAR) begin
      r_mem[r_clr_ptr] <= INIT_VAL;
    end else begin
      for (int p = 0; p < WRITE_PORTS; p++) begin
        if (w_wact[p]) begin
          for (int b = 0; b < BE; b++) begin
            if (w_wlane_we[p][b]) begin
              r_mem[bus.waddr[p]][b*BYTE_W +: BYTE_W] <= w_wlane_data[p][b*BYTE_W +: BYTE_W];
            end
          end
        end
      end
    end
  end

  // Collision pulse, one cycle after any lane saw more than one writer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_wr_collision <= 1'b0;
    else          r_wr_collision <= |w_wcoll;
  end

  // Per read port: array lookup, optional bypass, then ready/enable gating
  for (genvar r = 0; r < READ_PORTS; r++) begin : g_rd
    logic             w_in_range;
    logic [WIDTH-1:0] w_mem_word;
    logic [WIDTH-1:0] w_word;
    logic             w_rd_en;

    assign w_in_range = (int'(bus.raddr[r]) < DEPTH);
    assign w_mem_word = w_in_range ? r_mem[bus.raddr[r]] : '0;
    assign w_rd_en    = w_ready && bus.re[r];

    if (BYPASS_EN != 0) begin : g_byp
      logic [BE-1:0]    w_byp_we;
      logic [WIDTH-1:0] w_byp_data;
      logic             w_byp_coll_unused;

      mem_wr_merge #(
        .WRITE_PORTS (WRITE_PORTS),
        .AW          (AW),
        .WIDTH       (WIDTH)
      ) u_byp (
        .act       (w_wact),
        .waddr     (bus.waddr),
        .wbe       (bus.wbe),
        .wdata     (bus.wdata),
        .addr      (bus.raddr[r]),
        .lane_we   (w_byp_we),
        .lane_data (w_byp_data),
        .collision (w_byp_coll_unused)
      );

      // Lanes being written now take the new bytes, the rest the stored ones
      always_comb begin
        w_word = w_mem_word;
        for (int b = 0; b < BE; b++) begin
          if (w_byp_we[b]) w_word[b*BYTE_W +: BYTE_W] = w_byp_data[b*BYTE_W +: BYTE_W];
        end
      end
    end else begin : g_nobyp
      assign w_word = w_mem_word;
    end

    assign w_rdata_nxt[r]  = w_rd_en ? w_word : '0;
    assign w_rvalid_nxt[r] = w_rd_en;
  end

  if (READ_LATENCY != 0) begin : g_lat1
    logic [READ_PORTS-1:0][WIDTH-1:0] r_rdata;
    logic [READ_PORTS-1:0]            r_rvalid;

    // Registered read results, lost on reset
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_rdata  <= '0;
        r_rvalid <= '0;
      end else begin
        r_rdata  <= w_rdata_nxt;
        r_rvalid <= w_rvalid_nxt;
      end
    end

    assign bus.rdata  = r_rdata;
    assign bus.rvalid = r_rvalid;
  end else begin : g_lat0
    assign bus.rdata  = w_rdata_nxt;
    assign bus.rvalid = w_rvalid_nxt;
  end

  assign bus.ready        = w_ready;
  assign bus.wr_collision = r_wr_collision;

endmodule : mem_mp_be
`default_nettype wire

// File: tb/tb_mem_mp_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_mp_be
// Purpose  : Directed self-checking bench for mem_mp_be. Instance A: DEPTH 32,
//            bypass on, combinational reads. Instance B: DEPTH 20, bypass off,
//            registered reads. Read expectations go through per-instance
//            scoreboard queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_mp_be;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int na, nb;

  string       qa_t[$], qb_t[$];
  logic [31:0] qa_d[$], qb_d[$];
  logic        qa_v[$], qb_v[$];

  mem_mp_be_if #(.READ_PORTS(2), .WRITE_PORTS(2), .AW(5), .WIDTH(32)) ifa ();
  mem_mp_be_if #(.READ_PORTS(2), .WRITE_PORTS(2), .AW(5), .WIDTH(32)) ifb ();

  mem_mp_be #(
    .WIDTH(32), .DEPTH(32), .READ_PORTS(2), .WRITE_PORTS(2),
    .BYPASS_EN(1), .READ_LATENCY(0), .INIT_VAL(32'hA5A5A5A5)
  ) u_a (.clock(clock), .reset_n(reset_n), .bus(ifa.slave));

  mem_mp_be #(
    .WIDTH(32), .DEPTH(20), .READ_PORTS(2), .WRITE_PORTS(2),
    .BYPASS_EN(0), .READ_LATENCY(1), .INIT_VAL(32'hA5A5A5A5)
  ) u_b (.clock(clock), .reset_n(reset_n), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_a(input string t, input logic [31:0] d, input logic v);
    qa_t.push_back(t); qa_d.push_back(d); qa_v.push_back(v);
  endtask

  task automatic push_b(input string t, input logic [31:0] d, input logic v);
    qb_t.push_back(t); qb_d.push_back(d); qb_v.push_back(v);
  endtask

  task automatic idle();
    ifa.clear_req = 1'b0; ifa.re = '0; ifa.raddr = '0;
    ifa.we = '0; ifa.waddr = '0; ifa.wbe = '0; ifa.wdata = '0;
    ifb.clear_req = 1'b0; ifb.re = '0; ifb.raddr = '0;
    ifb.we = '0; ifb.waddr = '0; ifb.wbe = '0; ifb.wdata = '0;
  endtask

  // One clock: A checked mid-cycle, B checked just after the capturing edge
  task automatic cyc();
    string t;
    @(negedge clock);
    while (qa_d.size() > 0) begin
      t = qa_t.pop_front();
      chk({t, ".rdata"},  ifa.rdata[0], qa_d.pop_front());
      chk({t, ".rvalid"}, 32'(ifa.rvalid[0]), 32'(qa_v.pop_front()));
    end
    @(posedge clock); #1;
    while (qb_d.size() > 0) begin
      t = qb_t.pop_front();
      chk({t, ".rdata"},  ifb.rdata[0], qb_d.pop_front());
      chk({t, ".rvalid"}, 32'(ifb.rvalid[0]), 32'(qb_v.pop_front()));
    end
  endtask

  task automatic count_clear();
    na = 0; nb = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (!ifa.ready) na++;
      if (!ifb.ready) nb++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    idle();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_ready_a", 32'(ifa.ready), 32'd0);
    chk("rst_ready_b", 32'(ifb.ready), 32'd0);
    chk("rst_rvalid_b", 32'(ifb.rvalid), 32'd0);
    chk("rst_rdata_b", ifb.rdata[0], 32'd0);
    chk("rst_coll_a", 32'(ifa.wr_collision), 32'd0);

    // Initial clear length
    reset_n = 1'b1;
    count_clear();
    chk("clr_len_a", na, 32'd32);
    chk("clr_len_b", nb, 32'd20);
    @(posedge clock); #1;

    // Every entry holds INIT_VAL
    for (int i = 0; i < 32; i++) begin
      ifa.re[0] = 1'b1; ifa.raddr[0] = 5'(i);
      push_a("init_a", 32'hA5A5A5A5, 1'b1);
      if (i < 20) begin
        ifb.re[0] = 1'b1; ifb.raddr[0] = 5'(i);
        push_b("init_b", 32'hA5A5A5A5, 1'b1);
      end else begin
        ifb.re[0] = 1'b0;
      end
      cyc();
    end

    // Two ports, same address, overlapping lane 1
    idle();
    ifa.we = 2'b11; ifa.waddr[0] = 5'd5; ifa.wbe[0] = 4'b0011; ifa.wdata[0] = 32'h11223344;
    ifa.waddr[1] = 5'd5; ifa.wbe[1] = 4'b0110; ifa.wdata[1] = 32'hAABBCCDD;
    ifa.re[0] = 1'b1; ifa.raddr[0] = 5'd5;
    ifb.we = 2'b11; ifb.waddr[0] = 5'd5; ifb.wbe[0] = 4'b0011; ifb.wdata[0] = 32'h11223344;
    ifb.waddr[1] = 5'd5; ifb.wbe[1] = 4'b0110; ifb.wdata[1] = 32'hAABBCCDD;
    ifb.re[0] = 1'b1; ifb.raddr[0] = 5'd5;
    push_a("coll_byp_a", 32'hA5BBCC44, 1'b1);
    push_b("coll_nobyp_b", 32'hA5A5A5A5, 1'b1);
    cyc();
    chk("coll_a", 32'(ifa.wr_collision), 32'd1);
    chk("coll_b", 32'(ifb.wr_collision), 32'd1);
    idle();
    ifa.re[0] = 1'b1; ifa.raddr[0] = 5'd5;
    ifb.re[0] = 1'b1; ifb.raddr[0] = 5'd5;
    push_a("merged_a", 32'hA5BBCC44, 1'b1);
    push_b("merged_b", 32'hA5BBCC44, 1'b1);
    cyc();
    chk("coll_drop_a", 32'(ifa.wr_collision), 32'd0);
    chk("coll_drop_b", 32'(ifb.wr_collision), 32'd0);

    // Read-during-write of addr 7
    idle();
    ifa.we[0] = 1'b1; ifa.waddr[0] = 5'd7; ifa.wbe[0] = 4'hF; ifa.wdata[0] = 32'h0000BEEF;
    ifa.re[0] = 1'b1; ifa.raddr[0] = 5'd7;
    ifb.we[0] = 1'b1; ifb.waddr[0] = 5'd7; ifb.wbe[0] = 4'hF; ifb.wdata[0] = 32'h0000BEEF;
    ifb.re[0] = 1'b1; ifb.raddr[0] = 5'd7;
    push_a("rdw_byp_a", 32'h0000BEEF, 1'b1);
    push_b("rdw_old_b", 32'hA5A5A5A5, 1'b1);
    cyc();
    chk("single_wr_coll_a", 32'(ifa.wr_collision), 32'd0);
    idle();
    ifa.re[0] = 1'b1; ifa.raddr[0] = 5'd7;
    ifb.re[0] = 1'b1; ifb.raddr[0] = 5'd7;
    push_a("rdw_rep_a", 32'h0000BEEF, 1'b1);
    push_b("rdw_rep_b", 32'h0000BEEF, 1'b1);
    cyc();

    // wbe=0 on both ports is a no-op and no collision
    idle();
    ifa.we = 2'b11; ifa.waddr[0] = 5'd7; ifa.waddr[1] = 5'd7;
    ifa.wdata[0] = 32'hFFFFFFFF; ifa.wdata[1] = 32'hFFFFFFFF;
    ifa.re[0] = 1'b1; ifa.raddr[0] = 5'd7;
    push_a("wbe0_byp_a", 32'h0000BEEF, 1'b1);
    cyc();
    chk("wbe0_coll_a", 32'(ifa.wr_collision), 32'd0);
    idle();
    ifa.re[0] = 1'b1; ifa.raddr[0] = 5'd7;
    push_a("wbe0_keep_a", 32'h0000BEEF, 1'b1);
    cyc();

    // Full overlap: the higher port wins every lane
    idle();
    ifa.we = 2'b11; ifa.waddr[0] = 5'd9; ifa.waddr[1] = 5'd9;
    ifa.wbe[0] = 4'hF; ifa.wbe[1] = 4'hF;
    ifa.wdata[0] = 32'h11111111; ifa.wdata[1] = 32'h22222222;
    cyc();
    chk("overlap_coll_a", 32'(ifa.wr_collision), 32'd1);
    idle();
    ifa.re[0] = 1'b1; ifa.raddr[0] = 5'd9;
    push_a("high_port_wins_a", 32'h22222222, 1'b1);
    cyc();

    // Out-of-range access on the 20-entry instance
    idle();
    ifb.we[0] = 1'b1; ifb.waddr[0] = 5'd25; ifb.wbe[0] = 4'hF; ifb.wdata[0] = 32'hDEADBEEF;
    ifb.re[0] = 1'b1; ifb.raddr[0] = 5'd25;
    push_b("oor_rd_b", 32'd0, 1'b1);
    cyc();
    idle();
    ifb.re[0] = 1'b1; ifb.raddr[0] = 5'd5;
    push_b("oor_no_alias_b", 32'hA5BBCC44, 1'b1);
    cyc();

    // Disabled read
    idle();
    ifa.raddr[0] = 5'd5; ifb.raddr[0] = 5'd5;
    push_a("re0_a", 32'd0, 1'b0);
    push_b("re0_b", 32'd0, 1'b0);
    cyc();

    // Clear request with a simultaneous write and read on B
    idle();
    ifb.clear_req = 1'b1;
    ifb.we[0] = 1'b1; ifb.waddr[0] = 5'd3; ifb.wbe[0] = 4'hF; ifb.wdata[0] = 32'h12345678;
    ifb.re[0] = 1'b1; ifb.raddr[0] = 5'd3;
    push_b("last_rd_before_clr_b", 32'hA5A5A5A5, 1'b1);
    cyc();
    chk("clr_ready_fall_b", 32'(ifb.ready), 32'd0);
    ifb.clear_req = 1'b0;
    nb = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (k == 10) ifb.we = '0;
      if (!ifb.ready) begin
        nb++;
        if (k > 0) chk("clr_rvalid_b", 32'(ifb.rvalid[0]), 32'd0);
      end
    end
    chk("req_clr_len_b", nb, 32'd20);
    @(posedge clock); #1;
    ifb.re[0] = 1'b1; ifb.raddr[0] = 5'd3;
    push_b("post_clr_b", 32'hA5A5A5A5, 1'b1);
    cyc();

    // Reset in the middle of A's clear; B holds a registered read
    idle();
    ifb.re[0] = 1'b1; ifb.raddr[0] = 5'd3;
    ifa.clear_req = 1'b1;
    cyc();
    ifa.clear_req = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("pre_rst_rvalid_b", 32'(ifb.rvalid[0]), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async_rvalid_b", 32'(ifb.rvalid[0]), 32'd0);
    chk("async_rdata_b", ifb.rdata[0], 32'd0);
    chk("async_ready_a", 32'(ifa.ready), 32'd0);
    @(posedge clock); #1;
    idle();
    reset_n = 1'b1;
    count_clear();
    chk("restart_len_a", na, 32'd32);
    chk("restart_len_b", nb, 32'd20);
    @(posedge clock); #1;
    ifa.re[0] = 1'b1; ifa.raddr[0] = 5'd5;
    ifb.re[0] = 1'b1; ifb.raddr[0] = 5'd5;
    push_a("reinit_a", 32'hA5A5A5A5, 1'b1);
    push_b("reinit_b", 32'hA5A5A5A5, 1'b1);
    cyc();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mem_mp_be
`default_nettype wire
